// File: rtl/interrupt_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_vector_sequencer_pkg
// Description : Shared constants for the interrupt vector sequencer: state
//               encodings, interrupt kind codes, vector addresses, stack
//               page and pushed-status helper.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_vector_sequencer_pkg;

    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE     = 3'd0;
    localparam state_t c_ST_PUSH_PCH = 3'd1;
    localparam state_t c_ST_PUSH_PCL = 3'd2;
    localparam state_t c_ST_PUSH_P   = 3'd3;
    localparam state_t c_ST_FETCH_LO = 3'd4;
    localparam state_t c_ST_FETCH_HI = 3'd5;
    localparam state_t c_ST_LOAD     = 3'd6;

    // kind_o codes
    localparam logic [1:0] c_KIND_NONE = 2'b00;
    localparam logic [1:0] c_KIND_IRQ  = 2'b01;
    localparam logic [1:0] c_KIND_NMI  = 2'b10;
    localparam logic [1:0] c_KIND_RES  = 2'b11;

    localparam logic [15:0] c_VEC_NMI = 16'hFFFA;
    localparam logic [15:0] c_VEC_RES = 16'hFFFC;
    localparam logic [15:0] c_VEC_IRQ = 16'hFFFE;

    localparam logic [7:0] c_STACK_PAGE = 8'h01;

    // Status bits forced when P is pushed by a hardware interrupt
    localparam logic [7:0] c_P_BREAK  = 8'h10;
    localparam logic [7:0] c_P_UNUSED = 8'h20;

    function automatic logic [15:0] vector_base(input logic [1:0] kind);
        logic [15:0] v;
        case (kind)
            c_KIND_NMI: v = c_VEC_NMI;
            c_KIND_RES: v = c_VEC_RES;
            default:    v = c_VEC_IRQ;
        endcase
        return v;
    endfunction

    // Hardware interrupts push P with the unused bit set and B clear
    function automatic logic [7:0] pushed_status(input logic [7:0] p);
        return (p | c_P_UNUSED) & ~c_P_BREAK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_vector_sequencer_nmi_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : nmi_edge_detect
// Description : Registered rising-edge latch for the NMI request. A rising
//               edge on nmi_i sets pend_o; clr_i clears it. A new edge in
//               the same cycle as a clear wins so no edge is lost.
// Ports       : clk, rst_n (sync, active-low), nmi_i (level request),
//               clr_i (clear pending), pend_o (pending NMI flag)
// Revision    : 1.0 - initial release
// ============================================================================
module nmi_edge_detect
    import interrupt_vector_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_i,
    input  logic clr_i,
    output logic pend_o
);

    logic r_nmi_q;
    logic r_pend;
    logic w_rise;

    assign w_rise = nmi_i & ~r_nmi_q;
    assign pend_o = r_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nmi_q <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_nmi_q <= nmi_i;
            if (w_rise) begin
                r_pend <= 1'b1;
            end else if (clr_i) begin
                r_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/interrupt_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_vector_sequencer
// Description : Sequences RES/NMI/IRQ entry: pushes PCH, PCL and P onto the
//               stack page (not for RES), fetches the 16-bit vector and loads
//               it into the PC while setting the I flag.
// Ports       : clk, rst_n (sync, active-low)
//               sync_i            instruction-boundary strobe
//               res_i/nmi_i/irq_i conditioned requests, irq_mask_i = I flag
//               pc_i/sp_i/status_i CPU context to push
//               mem_ready_i/mem_rdata_i  memory handshake / read data
//               mem_addr_o/mem_rd_o/mem_wr_o/mem_wdata_o  memory request
//               sp_dec_o          one-cycle stack pointer decrement pulse
//               pc_load_o/pc_value_o  vector load into PC
//               set_i_flag_o, busy_o, kind_o (00 none/01 IRQ/10 NMI/11 RES)
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_vector_sequencer
    import interrupt_vector_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync_i,
    input  logic        res_i,
    input  logic        nmi_i,
    input  logic        irq_i,
    input  logic        irq_mask_i,
    input  logic [15:0] pc_i,
    input  logic [7:0]  sp_i,
    input  logic [7:0]  status_i,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        sp_dec_o,
    output logic        pc_load_o,
    output logic [15:0] pc_value_o,
    output logic        set_i_flag_o,
    output logic        busy_o,
    output logic [1:0]  kind_o
);

    // ------------------------------------------------------------------
    // State and captured context
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_kind;
    logic [7:0]  r_sp;      // local copy so push addresses do not depend on
                            // when the CPU applies sp_dec_o
    logic [15:0] r_pc;
    logic [7:0]  r_status;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;

    // Registered outputs
    logic [15:0] r_mem_addr;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [7:0]  r_mem_wdata;
    logic        r_sp_dec;
    logic        r_pc_load;
    logic [15:0] r_pc_value;
    logic        r_set_i;
    logic        r_busy;

    // Next-state values
    state_t      w_state_nx;
    logic [1:0]  w_kind_nx;
    logic [7:0]  w_sp_nx;
    logic [15:0] w_pc_nx;
    logic [7:0]  w_status_nx;
    logic [7:0]  w_lo_nx;
    logic [7:0]  w_hi_nx;
    logic        w_sp_dec_nx;

    // Next output values, decoded from the next state
    logic [15:0] w_addr_nx;
    logic        w_rd_nx;
    logic        w_wr_nx;
    logic [7:0]  w_wdata_nx;
    logic        w_pc_load_nx;
    logic [15:0] w_pc_value_nx;
    logic        w_set_i_nx;
    logic        w_busy_nx;

    logic        w_nmi_pend;
    logic        w_nmi_clr;
    logic        w_irq_ok;
    logic        w_abort;

    nmi_edge_detect u_nmi_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .nmi_i  (nmi_i),
        .clr_i  (w_nmi_clr),
        .pend_o (w_nmi_pend)
    );

    assign w_irq_ok = irq_i & ~irq_mask_i;
    // A reset request preempts any sequence other than a reset sequence;
    // re-aborting a reset sequence would stall it while res_i is held.
    assign w_abort  = (r_state != c_ST_IDLE) && res_i && (r_kind != c_KIND_RES);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_kind_nx   = r_kind;
        w_sp_nx     = r_sp;
        w_pc_nx     = r_pc;
        w_status_nx = r_status;
        w_lo_nx     = r_lo;
        w_hi_nx     = r_hi;
        w_sp_dec_nx = 1'b0;
        w_nmi_clr   = 1'b0;

        if (w_abort) begin
            // Any write in flight is dropped: no sp_dec_o for it
            w_state_nx = c_ST_FETCH_LO;
            w_kind_nx  = c_KIND_RES;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_kind_nx = c_KIND_NONE;
                    if (res_i) begin
                        w_state_nx = c_ST_FETCH_LO;
                        w_kind_nx  = c_KIND_RES;
                    end else if (sync_i && (w_nmi_pend || w_irq_ok)) begin
                        w_state_nx  = c_ST_PUSH_PCH;
                        w_kind_nx   = w_nmi_pend ? c_KIND_NMI : c_KIND_IRQ;
                        w_pc_nx     = pc_i;
                        w_sp_nx     = sp_i;
                        w_status_nx = status_i;
                    end
                end
                c_ST_PUSH_PCH: begin
                    if (mem_ready_i) begin
                        w_state_nx  = c_ST_PUSH_PCL;
                        w_sp_nx     = r_sp - 8'd1;
                        w_sp_dec_nx = 1'b1;
                    end
                end
                c_ST_PUSH_PCL: begin
                    if (mem_ready_i) begin
                        w_state_nx  = c_ST_PUSH_P;
                        w_sp_nx     = r_sp - 8'd1;
                        w_sp_dec_nx = 1'b1;
                    end
                end
                c_ST_PUSH_P: begin
                    if (mem_ready_i) begin
                        w_state_nx  = c_ST_FETCH_LO;
                        w_sp_nx     = r_sp - 8'd1;
                        w_sp_dec_nx = 1'b1;
                        // Kind is re-evaluated here: an NMI that arrived
                        // during an IRQ push takes over the vector fetch.
                        if (w_nmi_pend) begin
                            w_kind_nx = c_KIND_NMI;
                            w_nmi_clr = 1'b1;
                        end
                    end
                end
                c_ST_FETCH_LO: begin
                    if (mem_ready_i) begin
                        w_state_nx = c_ST_FETCH_HI;
                        w_lo_nx    = mem_rdata_i;
                    end
                end
                c_ST_FETCH_HI: begin
                    if (mem_ready_i) begin
                        w_state_nx = c_ST_LOAD;
                        w_hi_nx    = mem_rdata_i;
                    end
                end
                c_ST_LOAD: begin
                    w_state_nx = c_ST_IDLE;
                    w_kind_nx  = c_KIND_NONE;
                end
                default: begin
                    w_state_nx = c_ST_IDLE;
                    w_kind_nx  = c_KIND_NONE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode of the next state; registered below so every output
    // changes on the same edge as the state. While waiting the next state
    // equals the current one, which keeps the bus request stable.
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_nx     = 16'h0000;
        w_rd_nx       = 1'b0;
        w_wr_nx       = 1'b0;
        w_wdata_nx    = 8'h00;
        w_pc_load_nx  = 1'b0;
        w_pc_value_nx = 16'h0000;
        w_set_i_nx    = 1'b0;
        w_busy_nx     = (w_state_nx != c_ST_IDLE);

        case (w_state_nx)
            c_ST_PUSH_PCH: begin
                w_wr_nx    = 1'b1;
                w_addr_nx  = {c_STACK_PAGE, w_sp_nx};
                w_wdata_nx = w_pc_nx[15:8];
            end
            c_ST_PUSH_PCL: begin
                w_wr_nx    = 1'b1;
                w_addr_nx  = {c_STACK_PAGE, w_sp_nx};
                w_wdata_nx = w_pc_nx[7:0];
            end
            c_ST_PUSH_P: begin
                w_wr_nx    = 1'b1;
                w_addr_nx  = {c_STACK_PAGE, w_sp_nx};
                w_wdata_nx = pushed_status(w_status_nx);
            end
            c_ST_FETCH_LO: begin
                w_rd_nx   = 1'b1;
                w_addr_nx = vector_base(w_kind_nx);
            end
            c_ST_FETCH_HI: begin
                w_rd_nx   = 1'b1;
                w_addr_nx = vector_base(w_kind_nx) + 16'd1;
            end
            c_ST_LOAD: begin
                w_pc_load_nx  = 1'b1;
                w_pc_value_nx = {w_hi_nx, w_lo_nx};
                w_set_i_nx    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_kind      <= c_KIND_NONE;
            r_sp        <= 8'h00;
            r_pc        <= 16'h0000;
            r_status    <= 8'h00;
            r_lo        <= 8'h00;
            r_hi        <= 8'h00;
            r_mem_addr  <= 16'h0000;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= 8'h00;
            r_sp_dec    <= 1'b0;
            r_pc_load   <= 1'b0;
            r_pc_value  <= 16'h0000;
            r_set_i     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_kind      <= w_kind_nx;
            r_sp        <= w_sp_nx;
            r_pc        <= w_pc_nx;
            r_status    <= w_status_nx;
            r_lo        <= w_lo_nx;
            r_hi        <= w_hi_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_rd    <= w_rd_nx;
            r_mem_wr    <= w_wr_nx;
            r_mem_wdata <= w_wdata_nx;
            r_sp_dec    <= w_sp_dec_nx;
            r_pc_load   <= w_pc_load_nx;
            r_pc_value  <= w_pc_value_nx;
            r_set_i     <= w_set_i_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign mem_addr_o   = r_mem_addr;
    assign mem_rd_o     = r_mem_rd;
    assign mem_wr_o     = r_mem_wr;
    assign mem_wdata_o  = r_mem_wdata;
    assign sp_dec_o     = r_sp_dec;
    assign pc_load_o    = r_pc_load;
    assign pc_value_o   = r_pc_value;
    assign set_i_flag_o = r_set_i;
    assign busy_o       = r_busy;
    assign kind_o       = r_kind;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_vector_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_interrupt_vector_sequencer
// Description : Self-checking bench for interrupt_vector_sequencer. A
//               transaction-level model lists the bus transfers each
//               scenario must produce; a monitor matches completed transfers,
//               hold stability, sp_dec_o pulses and PC loads against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_i, res_i, nmi_i, irq_i, irq_mask_i;
    logic [15:0] pc_i;
    logic [7:0]  sp_i, status_i;
    logic        mem_ready_i;
    logic [7:0]  mem_rdata_i;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o, mem_wr_o;
    logic [7:0]  mem_wdata_o;
    logic        sp_dec_o, pc_load_o;
    logic [15:0] pc_value_o;
    logic        set_i_flag_o, busy_o;
    logic [1:0]  kind_o;

    interrupt_vector_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_i       (sync_i),
        .res_i        (res_i),
        .nmi_i        (nmi_i),
        .irq_i        (irq_i),
        .irq_mask_i   (irq_mask_i),
        .pc_i         (pc_i),
        .sp_i         (sp_i),
        .status_i     (status_i),
        .mem_ready_i  (mem_ready_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_wr_o     (mem_wr_o),
        .mem_wdata_o  (mem_wdata_o),
        .sp_dec_o     (sp_dec_o),
        .pc_load_o    (pc_load_o),
        .pc_value_o   (pc_value_o),
        .set_i_flag_o (set_i_flag_o),
        .busy_o       (busy_o),
        .kind_o       (kind_o)
    );

    always #5 clk = ~clk;

    // Vector table: NMI -> 5678, RES -> 1234, IRQ -> 9ABC
    function automatic logic [7:0] vec_byte(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h78;
            16'hFFFB: return 8'h56;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'hBC;
            16'hFFFF: return 8'h9A;
            default:  return 8'hEE;
        endcase
    endfunction

    assign mem_rdata_i = vec_byte(mem_addr_o);

    function automatic logic [15:0] model_base(input logic [1:0] k);
        case (k)
            2'b10:   return 16'hFFFA;
            2'b11:   return 16'hFFFC;
            default: return 16'hFFFE;
        endcase
    endfunction

    // Expected transfer list
    logic        exp_wr   [0:31];
    logic [15:0] exp_addr [0:31];
    logic [7:0]  exp_data [0:31];
    int          exp_wp = 0;
    int          exp_rp = 0;
    logic [15:0] exp_pc;
    logic [1:0]  exp_kind;

    int total = 0;
    int bad   = 0;
    int spdec_total = 0;
    int load_total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [15:0] a, input logic [7:0] d);
        exp_wr[exp_wp]   = wr;
        exp_addr[exp_wp] = a;
        exp_data[exp_wp] = d;
        exp_wp++;
    endtask

    // Interrupt entry pushes PCH, PCL, P on descending stack addresses
    task automatic plan_pushes(input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] st);
        logic [7:0] s;
        s = sp;
        push_exp(1'b1, {8'h01, s}, pc[15:8]);
        s = s - 8'd1;
        push_exp(1'b1, {8'h01, s}, pc[7:0]);
        s = s - 8'd1;
        push_exp(1'b1, {8'h01, s}, (st | 8'h20) & 8'hEF);
    endtask

    task automatic plan_vector(input logic [1:0] k);
        logic [15:0] b;
        b = model_base(k);
        push_exp(1'b0, b, 8'h00);
        push_exp(1'b0, b + 16'd1, 8'h00);
        exp_pc   = {vec_byte(b + 16'd1), vec_byte(b)};
        exp_kind = k;
    endtask

    // Compare process: runs every cycle on the falling edge
    task automatic monitor_loop();
        logic        p_strobe = 1'b0;
        logic        p_ready  = 1'b1;
        logic        p_res    = 1'b0;
        logic        p_wr     = 1'b0;
        logic        p_rd     = 1'b0;
        logic [15:0] p_addr   = 16'h0;
        logic [7:0]  p_wdata  = 8'h0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_strobe && !p_ready && !p_res) begin
                    check("hold_addr",  mem_addr_o,  p_addr);
                    check("hold_wr",    mem_wr_o,    p_wr);
                    check("hold_rd",    mem_rd_o,    p_rd);
                    check("hold_wdata", mem_wdata_o, p_wdata);
                end
                if ((mem_wr_o || mem_rd_o) && mem_ready_i) begin
                    if (exp_rp >= exp_wp) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_xfer: got wr=%0b addr=%h, required none", mem_wr_o, mem_addr_o);
                    end else begin
                        check("xfer_dir",  mem_wr_o,   exp_wr[exp_rp]);
                        check("xfer_addr", mem_addr_o, exp_addr[exp_rp]);
                        if (exp_wr[exp_rp]) check("xfer_wdata", mem_wdata_o, exp_data[exp_rp]);
                        exp_rp++;
                    end
                end
                if (sp_dec_o) spdec_total++;
                if (pc_load_o) begin
                    load_total++;
                    check("load_pc",    pc_value_o,   exp_pc);
                    check("load_kind",  kind_o,       exp_kind);
                    check("load_set_i", set_i_flag_o, 1'b1);
                    check("load_xfers_done", exp_rp, exp_wp);
                end
            end
            p_strobe = mem_wr_o | mem_rd_o;
            p_ready  = mem_ready_i;
            p_res    = res_i;
            p_wr     = mem_wr_o;
            p_rd     = mem_rd_o;
            p_addr   = mem_addr_o;
            p_wdata  = mem_wdata_o;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input string name, input logic [15:0] lit_pc, input logic [1:0] lit_kind);
        int n;
        n = 0;
        while (!pc_load_o && n < 50) begin
            step();
            n++;
        end
        if (!pc_load_o) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no pc_load_o in %0d cycles, required a load", name, n);
        end else begin
            check({name, "_pc_literal"},   pc_value_o, lit_pc);
            check({name, "_kind_literal"}, kind_o,     lit_kind);
        end
        step();
        check({name, "_idle_after"}, busy_o, 1'b0);
    endtask

    task automatic wait_write_at(input string name, input logic [15:0] a);
        int n;
        n = 0;
        while (!(mem_wr_o && mem_addr_o == a) && n < 20) begin
            step();
            n++;
        end
        if (!(mem_wr_o && mem_addr_o == a)) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got addr %h, required write at %h", name, mem_addr_o, a);
        end
    endtask

    initial begin
        int base;
        rst_n = 1'b0; sync_i = 1'b0; res_i = 1'b0; nmi_i = 1'b0; irq_i = 1'b0;
        irq_mask_i = 1'b0; pc_i = 16'h0; sp_i = 8'h0; status_i = 8'h0;
        mem_ready_i = 1'b1;
        fork
            monitor_loop();
        join_none

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr",     mem_addr_o,   16'h0000);
        check("rst_rd",       mem_rd_o,     1'b0);
        check("rst_wr",       mem_wr_o,     1'b0);
        check("rst_wdata",    mem_wdata_o,  8'h00);
        check("rst_sp_dec",   sp_dec_o,     1'b0);
        check("rst_pc_load",  pc_load_o,    1'b0);
        check("rst_pc_value", pc_value_o,   16'h0000);
        check("rst_set_i",    set_i_flag_o, 1'b0);
        check("rst_busy",     busy_o,       1'b0);
        check("rst_kind",     kind_o,       2'b00);
        rst_n = 1'b1;
        step();

        // ---- reset vector ----
        base = spdec_total;
        plan_vector(2'b11);
        res_i = 1'b1; sync_i = 1'b1;
        step();
        res_i = 1'b0; sync_i = 1'b0;
        check("res_first_addr", mem_addr_o, 16'hFFFC);
        check("res_first_rd",   mem_rd_o,   1'b1);
        check("res_first_wr",   mem_wr_o,   1'b0);
        wait_load("res", 16'h1234, 2'b11);
        check("res_no_spdec", spdec_total - base, 0);

        // ---- IRQ entry (literal expectations) ----
        base = spdec_total;
        pc_i = 16'hC0DE; sp_i = 8'hFD; status_i = 8'hC3; irq_i = 1'b1; irq_mask_i = 1'b0;
        push_exp(1'b1, 16'h01FD, 8'hC0);
        push_exp(1'b1, 16'h01FC, 8'hDE);
        push_exp(1'b1, 16'h01FB, 8'hE3);
        plan_vector(2'b01);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        check("irq_latency_wr",   mem_wr_o,   1'b1);
        check("irq_latency_addr", mem_addr_o, 16'h01FD);
        check("irq_busy",         busy_o,     1'b1);
        wait_load("irq", 16'h9ABC, 2'b01);
        irq_i = 1'b0;
        check("irq_spdec_count", spdec_total - base, 3);

        // ---- masked IRQ ----
        irq_i = 1'b1; irq_mask_i = 1'b1; sync_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("masked_busy", busy_o, 1'b0);
        end
        sync_i = 1'b0; irq_i = 1'b0; irq_mask_i = 1'b0;
        step();

        // ---- NMI hijacks an IRQ push ----
        pc_i = 16'h1357; sp_i = 8'hF0; status_i = 8'h00; irq_i = 1'b1;
        plan_pushes(16'h1357, 8'hF0, 8'h00);
        plan_vector(2'b10);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        wait_write_at("nmi_pcl", 16'h01EF);
        nmi_i = 1'b1;
        wait_load("nmi", 16'h5678, 2'b10);
        irq_i = 1'b0; nmi_i = 1'b0;
        step();
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        check("nmi_pend_cleared", busy_o, 1'b0);
        step();

        // ---- wait states in PUSH_P ----
        pc_i = 16'hABCD; sp_i = 8'h80; status_i = 8'h1F; irq_i = 1'b1;
        plan_pushes(16'hABCD, 8'h80, 8'h1F);
        plan_vector(2'b01);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        wait_write_at("wait_p", 16'h017E);
        mem_ready_i = 1'b0;
        step();
        base = spdec_total;
        check("wait_addr", mem_addr_o,  16'h017E);
        check("wait_data", mem_wdata_o, 8'h2F);
        step();
        check("wait_addr", mem_addr_o,  16'h017E);
        check("wait_data", mem_wdata_o, 8'h2F);
        step();
        check("wait_addr", mem_addr_o,  16'h017E);
        check("wait_wr",   mem_wr_o,    1'b1);
        check("wait_no_spdec", spdec_total - base, 0);
        mem_ready_i = 1'b1;
        wait_load("wait", 16'h9ABC, 2'b01);
        irq_i = 1'b0;
        check("wait_spdec_once", spdec_total - base, 1);

        // ---- reset aborts an IRQ in PUSH_PCL ----
        base = spdec_total;
        pc_i = 16'h2468; sp_i = 8'h40; status_i = 8'h00; irq_i = 1'b1;
        push_exp(1'b1, 16'h0140, 8'h24);
        plan_vector(2'b11);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        wait_write_at("abort_pcl", 16'h013F);
        res_i = 1'b1; mem_ready_i = 1'b0;
        step();
        res_i = 1'b0; mem_ready_i = 1'b1; irq_i = 1'b0;
        check("abort_addr", mem_addr_o, 16'hFFFC);
        check("abort_rd",   mem_rd_o,   1'b1);
        check("abort_wr",   mem_wr_o,   1'b0);
        check("abort_kind", kind_o,     2'b11);
        wait_load("abort", 16'h1234, 2'b11);
        check("abort_spdec", spdec_total - base, 1);

        // ---- end of run ----
        step();
        check("all_xfers_done", exp_rp, exp_wp);
        check("load_count", load_total, 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
